// File: rtl/nn_pkg.sv
// Shared definitions for the neuron-layer sequencer: state encodings and size defaults.
package nn_pkg;

    localparam int NN_MAX_NEURONS = 16;
    localparam int NN_IDX_W       = 4;

    // Encodings are fixed so the datapath and debug tooling can decode state directly.
    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_INIT  = 3'b001,
        S_FETCH = 3'b010,
        S_MULT  = 3'b011,
        S_ADD1  = 3'b100,
        S_ADD2  = 3'b110,
        S_WRITE = 3'b101,
        S_DONE  = 3'b111
    } state_e;

endpackage

// File: rtl/nn_idx_counter.sv
// Neuron index and per-run neuron count for the layer sequencer.
// The count is clamped to MAX_NEURONS when loaded, so idx can never run past it.
module nn_idx_counter
    import nn_pkg::*;
#(
    parameter int MAX_NEURONS = NN_MAX_NEURONS,
    parameter int IDX_W       = NN_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [IDX_W:0]   cfg_count_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);

    localparam logic [IDX_W:0]   MAX_CNT = MAX_NEURONS[IDX_W:0];
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   count_q, count_d;

    // Next index/count: clear dominates load, load dominates increment; increment stops at the last neuron.
    always_comb begin
        idx_d   = idx_q;
        count_d = count_q;
        if (clear_i) begin
            idx_d   = '0;
            count_d = '0;
        end else if (load_i) begin
            idx_d   = '0;
            count_d = (cfg_count_i > MAX_CNT) ? MAX_CNT : cfg_count_i;
        end else if (inc_i && !last_o) begin
            idx_d   = idx_q + IDX_ONE;
        end
    end

    // Index and count registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (({1'b0, idx_q} + CNT_ONE) == count_q);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Layer sequencer: walks the shared MAC datapath through FETCH/MULT/ADD1/ADD2/WRITE
// for every neuron of a layer. Outputs are pure decodes of the registered state and index.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int MAX_NEURONS = NN_MAX_NEURONS,
    parameter int IDX_W       = NN_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W:0]   cfg_count,
    input  logic             mem_ready,
    output logic             busy,
    output logic             init,
    output logic             w_rd_en,
    output logic [IDX_W-1:0] w_addr,
    output logic             mult_en,
    output logic             add1_en,
    output logic             add2_en,
    output logic             write_reg,
    output logic [IDX_W-1:0] wr_addr,
    output logic             done
);

    state_e           state_q, state_d;
    logic             cnt_clear, cnt_load, cnt_inc;
    logic             last;
    logic [IDX_W-1:0] idx;

    nn_idx_counter #(
        .MAX_NEURONS (MAX_NEURONS),
        .IDX_W       (IDX_W)
    ) u_idx (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (cnt_clear),
        .load_i      (cnt_load),
        .inc_i       (cnt_inc),
        .cfg_count_i (cfg_count),
        .idx_o       (idx),
        .last_o      (last)
    );

    // Next-state and counter control; abort outside IDLE overrides every other transition.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT: begin
                if (!start) begin
                    cnt_load = 1'b1;
                    state_d  = (cfg_count != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: if (mem_ready) state_d = S_MULT;
            S_MULT:  state_d = S_ADD1;
            S_ADD1:  state_d = S_ADD2;
            S_ADD2:  state_d = S_WRITE;
            S_WRITE: begin
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                cnt_clear = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            cnt_clear = 1'b1;
            cnt_load  = 1'b0;
            cnt_inc   = 1'b0;
        end
    end

    // State register; reset drops straight to IDLE, abandoning any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign init      = (state_q == S_INIT);
    assign w_rd_en   = (state_q == S_FETCH);
    assign mult_en   = (state_q == S_MULT);
    assign add1_en   = (state_q == S_ADD1);
    assign add2_en   = (state_q == S_ADD2);
    assign write_reg = (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    assign w_addr    = idx;
    assign wr_addr   = idx;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Testbench for nn_layer_sequencer: a run-level trace model builds the expected
// per-cycle outputs from neuron count, start hold, stalls and abort point.
module tb_nn_layer_sequencer;

    localparam int MAXN = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mem_ready = 1'b0;
    logic [4:0] cfg_count = '0;
    logic       busy, init, w_rd_en, mult_en, add1_en, add2_en, write_reg, done;
    logic [3:0] w_addr, wr_addr;

    nn_layer_sequencer #(.MAX_NEURONS(16), .IDX_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_count (cfg_count),
        .mem_ready (mem_ready),
        .busy      (busy),
        .init      (init),
        .w_rd_en   (w_rd_en),
        .w_addr    (w_addr),
        .mult_en   (mult_en),
        .add1_en   (add1_en),
        .add2_en   (add2_en),
        .write_reg (write_reg),
        .wr_addr   (wr_addr),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       abort;
        logic       mem_ready;
        logic [4:0] cfg;
    } stim_t;

    typedef struct packed {
        logic       busy;
        logic       init;
        logic       rd;
        logic [3:0] waddr;
        logic       mult;
        logic       add1;
        logic       add2;
        logic       wr;
        logic [3:0] wraddr;
        logic       done;
    } obs_t;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    obs_t  exp_cur = '0;
    obs_t  act;
    logic  chk_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int m_wr = 0, m_done = 0, m_rd = 0, m_first_rd = 0, m_done_cyc = 0, m_last_wraddr = 0;

    assign act = {busy, init, w_rd_en, w_addr, mult_en, add1_en, add2_en,
                  write_reg, wr_addr, done};

    function automatic obs_t masked(input obs_t v, input logic rd, input logic wr);
        obs_t r;
        r = v;
        if (!rd) r.waddr = '0;
        if (!wr) r.wraddr = '0;
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Per-cycle comparison against the model trace, plus event monitors.
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_en) begin
                n_cmp++;
                a = masked(act, exp_cur.rd, exp_cur.wr);
                e = masked(exp_cur, exp_cur.rd, exp_cur.wr);
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cyc%0d outputs: got %h want %h", cyc, a, e);
                end
            end
            if (write_reg === 1'b1) begin
                m_wr++;
                m_last_wraddr = int'(wr_addr);
            end
            if (done === 1'b1) begin
                m_done++;
                m_done_cyc = cyc;
            end
            if (w_rd_en === 1'b1) begin
                if (m_rd == 0) m_first_rd = cyc;
                m_rd++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic mon_clear();
        m_wr = 0; m_done = 0; m_rd = 0; m_first_rd = 0; m_done_cyc = 0; m_last_wraddr = 0;
    endtask

    task automatic push(input stim_t s, input obs_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    function automatic stim_t filler(input bit noisy);
        stim_t s;
        s = '0;
        s.mem_ready = 1'b1;
        if (noisy) begin
            s.start     = 1'($urandom_range(0, 1));
            s.mem_ready = 1'($urandom_range(0, 1));
            s.cfg       = 5'($urandom_range(0, 31));
        end
        return s;
    endfunction

    // Build the expected trace of one run: IDLE+start, INIT for 'hold' cycles,
    // then five phases per neuron (FETCH stretched by stalls), DONE, idle tail.
    task automatic gen_run(input int cfg, input int hold, input int stall0,
                           input int abort_at, input bit noisy);
        int    cnt, base, st;
        stim_t s, t;
        obs_t  e;
        cnt  = (cfg > MAXN) ? MAXN : cfg;
        base = stim_q.size();
        s = '0; s.start = 1'b1; s.mem_ready = 1'b1; s.cfg = cfg[4:0];
        e = '0;
        push(s, e);
        for (int k = 1; k <= hold; k++) begin
            s.start = (k < hold);
            e = '0; e.busy = 1'b1; e.init = 1'b1;
            push(s, e);
        end
        for (int n = 0; n < cnt; n++) begin
            st = (n == 0) ? stall0 : 0;
            for (int j = 0; j <= st; j++) begin
                s = filler(noisy);
                s.mem_ready = (j == st);
                e = '0; e.busy = 1'b1; e.rd = 1'b1; e.waddr = n[3:0];
                push(s, e);
            end
            e = '0; e.busy = 1'b1; e.mult = 1'b1; push(filler(noisy), e);
            e = '0; e.busy = 1'b1; e.add1 = 1'b1; push(filler(noisy), e);
            e = '0; e.busy = 1'b1; e.add2 = 1'b1; push(filler(noisy), e);
            e = '0; e.busy = 1'b1; e.wr = 1'b1; e.wraddr = n[3:0]; push(filler(noisy), e);
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1; push(filler(noisy), e);
        for (int k = 0; k < 3; k++) begin
            s = '0; e = '0;
            push(s, e);
        end
        if (abort_at >= 0) begin
            t = stim_q[base + abort_at];
            t.abort = 1'b1;
            stim_q[base + abort_at] = t;
            for (int i = base + abort_at + 1; i < stim_q.size(); i++) begin
                t = stim_q[i];
                t.start = 1'b0;
                stim_q[i] = t;
                exp_q[i] = '0;
            end
        end
    endtask

    task automatic play_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            start     = stim_q[i].start;
            abort     = stim_q[i].abort;
            mem_ready = stim_q[i].mem_ready;
            cfg_count = stim_q[i].cfg;
            exp_cur   = exp_q[i];
            chk_en    = 1'b1;
        end
    endtask

    task automatic play_all();
        play_n(stim_q.size());
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        stim_q.delete();
        exp_q.delete();
    endtask

    function automatic int find_first_wr();
        for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].wr) return i;
        return -1;
    endfunction

    function automatic int find_done();
        for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].done) return i;
        return -1;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'(act), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal: three neurons, start held two cycles.
        gen_run(3, 2, 0, -1, 1'b0);
        chk("model_first_write_cycle", find_first_wr(), 7);
        chk("model_done_cycle", find_done(), 18);
        mon_clear();
        play_all();
        chk("nominal_writes", m_wr, 3);
        chk("nominal_last_wraddr", m_last_wraddr, 2);
        chk("nominal_done", m_done, 1);
        chk("nominal_fetch_to_done", m_done_cyc - m_first_rd, 15);

        // Memory stall of four cycles on the first fetch.
        gen_run(2, 1, 4, -1, 1'b0);
        mon_clear();
        play_all();
        chk("stall_fetch_cycles", m_rd, 6);
        chk("stall_fetch_to_done", m_done_cyc - m_first_rd, 14);
        chk("stall_writes", m_wr, 2);

        // Zero count.
        gen_run(0, 1, 0, -1, 1'b0);
        mon_clear();
        play_all();
        chk("zero_done", m_done, 1);
        chk("zero_writes", m_wr, 0);
        chk("zero_fetches", m_rd, 0);

        // Abort in ADD1 of neuron 1.
        gen_run(4, 1, 0, 9, 1'b0);
        mon_clear();
        play_all();
        chk("abort_add1_writes", m_wr, 1);
        chk("abort_add1_wraddr", m_last_wraddr, 0);
        chk("abort_add1_done", m_done, 0);

        // Abort together with mem_ready in the first FETCH.
        gen_run(2, 1, 0, 2, 1'b0);
        mon_clear();
        play_all();
        chk("abort_fetch_writes", m_wr, 0);
        chk("abort_fetch_done", m_done, 0);

        // Abort in WRITE of neuron 0.
        gen_run(2, 1, 0, 6, 1'b0);
        mon_clear();
        play_all();
        chk("abort_write_writes", m_wr, 1);
        chk("abort_write_done", m_done, 0);

        // Abort in INIT.
        gen_run(2, 1, 0, 1, 1'b0);
        mon_clear();
        play_all();
        chk("abort_init_fetches", m_rd, 0);

        // Count clamp with noisy start/cfg_count/mem_ready while busy.
        gen_run(17, 2, 0, -1, 1'b1);
        mon_clear();
        play_all();
        chk("clamp_writes", m_wr, 16);
        chk("clamp_last_wraddr", m_last_wraddr, 15);
        chk("clamp_done", m_done, 1);

        // Asynchronous reset during MULT of neuron 2, then a clean one-neuron run.
        gen_run(3, 1, 0, -1, 1'b0);
        mon_clear();
        play_n(14);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrun_reset_outputs", int'(act), 0);
        start = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("held_reset_outputs", int'(act), 0);
        @(negedge clk);
        rst_n = 1'b1;
        stim_q.delete();
        exp_q.delete();
        gen_run(1, 1, 0, -1, 1'b0);
        mon_clear();
        play_all();
        chk("post_reset_writes", m_wr, 1);
        chk("post_reset_wraddr", m_last_wraddr, 0);
        chk("post_reset_done", m_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
